msrv32_store_buffer: RTL and testbench
======================================

MSRV32_STORE_BUFFER -- requirements
Module: msrv32_store_buffer

Interface
REQ-001 Parameter DATA_W, default 32, meaning bus/store data width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 4, meaning store queue entries; power of two, 2..16.
REQ-003 ms_riscv32_mp_clk_in  input  1  meaning single clock; all state updates on rising edge.
REQ-004 ms_riscv32_mp_rst_in  input  1  meaning reset, synchronous, active-high.
REQ-005 funct3_in  input  3  meaning store size: 000 SB, 001 SH, 010 SW, 011 SD (legal only when DATA_W=64).
REQ-006 iadder_in  input  32  meaning byte address of store.
REQ-007 rs2_in  input  DATA_W  meaning store data, LSB-justified.
REQ-008 mem_wr_req_in  input  1  meaning store request, one-cycle pulse per store.
REQ-009 stall_out  output  1  meaning queue full; core holds request.
REQ-010 store_err_out  output  1  meaning misaligned/illegal store flagged, registered pulse.
REQ-011 ahb_ready_in  input  1  meaning bus HREADY.
REQ-012 d_addr_out  output  32  meaning address-phase address, aligned to DATA_W/8 bytes.
REQ-013 ahb_htrans_out  output  2  meaning 2'b10 NONSEQ when head entry valid, else 2'b00 IDLE.
REQ-014 data_out  output  DATA_W  meaning data-phase write data, lane-aligned.
REQ-015 wr_mask_out  output  DATA_W/8  meaning data-phase byte strobes.
REQ-016 wr_req_out  output  1  meaning data phase in progress.
REQ-017 count_out  output  $clog2(DEPTH+1)  meaning entries queued (excludes data-phase entry).

Function
REQ-018 Lane = iadder_in low log2(DATA_W/8) bits; data SHALL be replicated-free: selected bytes placed at lane, other bytes zero, mask bits set only for written bytes.
REQ-019 Misaligned: SH with addr[0]=1, SW with addr[1:0]!=0, SD with addr[2:0]!=0; illegal: funct3[2]=1 or SD with DATA_W=32; either SHALL set store_err_out for exactly one cycle after the request and SHALL NOT enqueue.
REQ-020 Legal request with mem_wr_req_in=1 and stall_out=0 SHALL enqueue {aligned addr, lane data, mask} at the tail; count_out increments next cycle.
REQ-021 Request while stall_out=1 SHALL be ignored (no enqueue, no error).
REQ-022 stall_out SHALL equal (count_out==DEPTH), registered; no full-queue bypass.
REQ-023 Address phase: when count_out>0, ahb_htrans_out=10 and d_addr_out=head address, combinationally from head; else htrans=00 and d_addr_out holds last value.
REQ-024 On a clock edge with ahb_ready_in=1: current data phase (if any) SHALL complete (wr_req_out falls unless replaced), and if htrans=10 the head SHALL pop into the data-phase register (data_out, wr_mask_out, wr_req_out=1).
REQ-025 With ahb_ready_in=0, head, data-phase register, data_out, wr_mask_out and d_addr_out SHALL hold stable.
REQ-026 Simultaneous enqueue and pop SHALL leave count_out unchanged; pointers wrap modulo DEPTH.
REQ-027 Minimum latency: request at edge N -> htrans=10 during cycle N+1 -> data phase cycle N+2 with ahb_ready_in=1 throughout.
REQ-028 Back-to-back: with ahb_ready_in=1 continuously, one store SHALL retire per cycle.
REQ-029 When wr_req_out=0, data_out and wr_mask_out SHALL be 0.

Reset
REQ-030 Reset SHALL clear pointers, count_out=0, stall_out=0, store_err_out=0, wr_req_out=0, data_out=0, wr_mask_out=0, d_addr_out=0, htrans=00.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight stores; reset overrides a simultaneous request.

Verification
REQ-032 SB addr 0x103, rs2=0xAABBCCDD, DATA_W=32, ready=1 -> cycle+1 d_addr=0x100 htrans=10; cycle+2 data_out=0xDD000000, mask=1000, wr_req=1.
REQ-033 SH addr 0x101 -> store_err_out=1 one cycle, count_out stays 0, htrans stays 00.
REQ-034 ready=0, push DEPTH stores -> stall_out=1, extra request ignored; release ready -> stores retire in order, one per cycle, stall_out falls after first pop.
REQ-035 ready toggled 0 during data phase of SW 0x200 data 0x12345678 -> data_out/mask held until ready=1, next address not advanced.
REQ-036 DATA_W=64, SD addr 0x108 -> mask=0xFF; SD addr 0x10C -> store_err_out=1.
REQ-037 Reset asserted with 2 queued + 1 in data phase -> next cycle count_out=0, wr_req_out=0, htrans=00.

Source files
------------

// File: rtl/msrv32_store_buffer.sv
// Store buffer between the core's store path and an AHB-style write port.
// Legal stores are lane-aligned and queued, then issued one address phase and one data phase per store.
module msrv32_store_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         ms_riscv32_mp_clk_in,
   input  logic                         ms_riscv32_mp_rst_in,
   input  logic [2:0]                   funct3_in,
   input  logic [31:0]                  iadder_in,
   input  logic [DATA_W-1:0]            rs2_in,
   input  logic                         mem_wr_req_in,
   output logic                         stall_out,
   output logic                         store_err_out,
   input  logic                         ahb_ready_in,
   output logic [31:0]                  d_addr_out,
   output logic [1:0]                   ahb_htrans_out,
   output logic [DATA_W-1:0]            data_out,
   output logic [DATA_W/8-1:0]          wr_mask_out,
   output logic                         wr_req_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [31:0]       addr;
      logic [DATA_W-1:0] data;
      logic [BYTES-1:0]  mask;
   } entry_t;

   entry_t              queue_q [DEPTH];
   entry_t              new_entry;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]    count_nxt;
   logic [31:0]         last_addr;
   logic [LANE_W-1:0]   lane;
   logic [DATA_W-1:0]   size_data;
   logic [BYTES-1:0]    size_mask;
   logic                misaligned;
   logic                illegal;
   logic                legal;
   logic                push;
   logic                pop;
   logic                head_valid;

   assign lane = iadder_in[LANE_W-1:0];

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      size_data  = '0;
      size_mask  = '0;
      misaligned = 1'b0;
      case (funct3_in[1:0])
         2'b00: begin
            size_data = DATA_W'(rs2_in[7:0]);
            size_mask = BYTES'(1'b1);
         end
         2'b01: begin
            size_data  = DATA_W'(rs2_in[15:0]);
            size_mask  = BYTES'(2'b11);
            misaligned = iadder_in[0];
         end
         2'b10: begin
            size_data  = DATA_W'(rs2_in[31:0]);
            size_mask  = BYTES'(4'hF);
            misaligned = |iadder_in[1:0];
         end
         default: begin
            size_data  = rs2_in;
            size_mask  = '1;
            misaligned = |iadder_in[2:0];
         end
      endcase
   end

   assign illegal = funct3_in[2] | ((funct3_in[1:0] == 2'b11) && (DATA_W != 64));
   assign legal   = ~illegal & ~misaligned;

   // Selected bytes land in their byte lane; unused lanes stay zero.
   assign new_entry.addr = {iadder_in[31:LANE_W], {LANE_W{1'b0}}};
   assign new_entry.data = size_data << {lane, 3'b000};
   assign new_entry.mask = size_mask << lane;

   assign head_valid = (count_out != '0);
   assign push       = mem_wr_req_in & ~stall_out & legal;
   assign pop        = ahb_ready_in & head_valid;
   assign count_nxt  = count_out + CNT_W'(push) - CNT_W'(pop);

   assign ahb_htrans_out = head_valid ? 2'b10 : 2'b00;
   assign d_addr_out     = head_valid ? queue_q[rd_ptr].addr : last_addr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (ms_riscv32_mp_rst_in) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count_out     <= '0;
         stall_out     <= 1'b0;
         store_err_out <= 1'b0;
         wr_req_out    <= 1'b0;
         data_out      <= '0;
         wr_mask_out   <= '0;
         last_addr     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            last_addr <= queue_q[rd_ptr].addr;
         end
         count_out     <= count_nxt;
         stall_out     <= (count_nxt == CNT_W'(DEPTH));
         store_err_out <= mem_wr_req_in & ~stall_out & ~legal;
         if (ahb_ready_in) begin
            wr_req_out  <= pop;
            data_out    <= pop ? queue_q[rd_ptr].data : '0;
            wr_mask_out <= pop ? queue_q[rd_ptr].mask : '0;
         end
      end
   end

   // NOTE: queue storage is not reset; entries are only visible through the reset pointers and count.
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (push) begin
         queue_q[wr_ptr] <= new_entry;
      end
   end

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// Bench for msrv32_store_buffer: directed literal cases plus randomized traffic
// compared every cycle against a queue-based model of the store buffer.
`timescale 1ns/1ps
module tb_msrv32_store_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int BYTES = DW / 8;

   typedef struct {
      logic [31:0]      addr;
      logic [DW-1:0]    data;
      logic [BYTES-1:0] mask;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    funct3;
   logic [31:0]   addr;
   logic [31:0]   rs2;
   logic          req;
   logic          ready;
   logic          stall;
   logic          err;
   logic [31:0]   d_addr;
   logic [1:0]    htrans;
   logic [31:0]   data;
   logic [3:0]    mask;
   logic          wr_req;
   logic [2:0]    count;

   logic [2:0]    f3_64;
   logic [31:0]   addr_64;
   logic [63:0]   rs2_64;
   logic          req_64;
   logic          ready_64;
   logic          stall_64;
   logic          err_64;
   logic [31:0]   d_addr_64;
   logic [1:0]    htrans_64;
   logic [63:0]   data_64;
   logic [7:0]    mask_64;
   logic          wr_req_64;
   logic [2:0]    count_64;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   msrv32_store_buffer #(.DATA_W(32), .DEPTH(DEPTH)) u_dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .funct3_in            (funct3),
      .iadder_in            (addr),
      .rs2_in               (rs2),
      .mem_wr_req_in        (req),
      .stall_out            (stall),
      .store_err_out        (err),
      .ahb_ready_in         (ready),
      .d_addr_out           (d_addr),
      .ahb_htrans_out       (htrans),
      .data_out             (data),
      .wr_mask_out          (mask),
      .wr_req_out           (wr_req),
      .count_out            (count)
   );

   msrv32_store_buffer #(.DATA_W(64), .DEPTH(4)) u_dut64 (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .funct3_in            (f3_64),
      .iadder_in            (addr_64),
      .rs2_in               (rs2_64),
      .mem_wr_req_in        (req_64),
      .stall_out            (stall_64),
      .store_err_out        (err_64),
      .ahb_ready_in         (ready_64),
      .d_addr_out           (d_addr_64),
      .ahb_htrans_out       (htrans_64),
      .data_out             (data_64),
      .wr_mask_out          (mask_64),
      .wr_req_out           (wr_req_64),
      .count_out            (count_64)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the 32-bit instance ----------------
   entry_t        m_q[$];
   logic [31:0]   m_data   = '0;
   logic [3:0]    m_mask   = '0;
   logic          m_wr_req = 1'b0;
   logic          m_err    = 1'b0;
   logic [31:0]   m_last   = '0;
   bit            m_live   = 1'b0;

   function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0:    return 1'b1;
         3'd1:    return (a % 2) == 0;
         3'd2:    return (a % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic entry_t m_entry(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      entry_t e;
      int nbytes;
      int lane;
      nbytes = 1 << f3[1:0];
      lane   = int'(a % BYTES);
      e.addr = a - 32'(lane);
      e.data = '0;
      e.mask = '0;
      for (int b = 0; b < nbytes; b++) begin
         e.data[(lane + b) * 8 +: 8] = d[b * 8 +: 8];
         e.mask[lane + b]            = 1'b1;
      end
      return e;
   endfunction

   initial begin
      entry_t e;
      bit     full;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_q.delete();
            m_data   = '0;
            m_mask   = '0;
            m_wr_req = 1'b0;
            m_err    = 1'b0;
            m_last   = '0;
         end else begin
            full = (m_q.size() == DEPTH);
            if (ready) begin
               if (m_q.size() != 0) begin
                  e        = m_q.pop_front();
                  m_data   = e.data;
                  m_mask   = e.mask;
                  m_wr_req = 1'b1;
                  m_last   = e.addr;
               end else begin
                  m_data   = '0;
                  m_mask   = '0;
                  m_wr_req = 1'b0;
               end
            end
            m_err = req && !full && !m_legal(funct3, addr);
            if (req && !full && m_legal(funct3, addr)) begin
               m_q.push_back(m_entry(funct3, addr, rs2));
            end
         end
         m_live = 1'b1;
      end
   end

   // Per-cycle compare, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("count",  64'(count),  64'(m_q.size()));
            check("stall",  64'(stall),  64'(m_q.size() == DEPTH));
            check("err",    64'(err),    64'(m_err));
            check("htrans", 64'(htrans), (m_q.size() != 0) ? 64'd2 : 64'd0);
            check("d_addr", 64'(d_addr), (m_q.size() != 0) ? 64'(m_q[0].addr) : 64'(m_last));
            check("wr_req", 64'(wr_req), 64'(m_wr_req));
            check("data",   64'(data),   64'(m_data));
            check("mask",   64'(mask),   64'(m_mask));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic r, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy);
      req    = r;
      funct3 = f;
      addr   = a;
      rs2    = d;
      ready  = rdy;
   endtask

   task automatic drive64(input logic r, input logic [2:0] f, input logic [31:0] a,
                          input logic [63:0] d, input logic rdy);
      req_64   = r;
      f3_64    = f;
      addr_64  = a;
      rs2_64   = d;
      ready_64 = rdy;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      drive64(1'b0, 3'd0, 32'h0, 64'h0, 1'b1);
      repeat (3) tick();
      check("reset_count",  64'(count),  64'd0);
      check("reset_htrans", 64'(htrans), 64'd0);
      check("reset_d_addr", 64'(d_addr), 64'd0);
      check("reset_wr_req", 64'(wr_req), 64'd0);
      rst = 1'b0;
      tick();

      // SB to 0x103: lane 3, min latency
      drive(1'b1, 3'd0, 32'h103, 32'hAABBCCDD, 1'b1);
      tick();
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      check("sb_htrans", 64'(htrans), 64'd2);
      check("sb_d_addr", 64'(d_addr), 64'h100);
      tick();
      check("sb_wr_req", 64'(wr_req), 64'd1);
      check("sb_data",   64'(data),   64'hDD000000);
      check("sb_mask",   64'(mask),   64'h8);
      tick();
      check("sb_idle_data", 64'(data),   64'd0);
      check("sb_idle_req",  64'(wr_req), 64'd0);

      // misaligned SH
      drive(1'b1, 3'd1, 32'h101, 32'h1234, 1'b1);
      tick();
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      check("sh_mis_err",    64'(err),    64'd1);
      check("sh_mis_count",  64'(count),  64'd0);
      check("sh_mis_htrans", 64'(htrans), 64'd0);
      tick();
      check("sh_mis_err_pulse", 64'(err), 64'd0);

      // fill with ready low, extra request ignored, then drain in order
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 3'd2, 32'h300 + 32'(4 * i), 32'(i + 1), 1'b0);
         tick();
      end
      check("full_stall",  64'(stall),  64'd1);
      check("full_count",  64'(count),  64'd4);
      check("full_d_addr", 64'(d_addr), 64'h300);
      drive(1'b1, 3'd2, 32'h400, 32'hEE, 1'b0);
      tick();
      check("full_ignore_count", 64'(count), 64'd4);
      check("full_ignore_err",   64'(err),   64'd0);
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      tick();
      check("drain_stall", 64'(stall), 64'd0);
      check("drain_count", 64'(count), 64'd3);
      check("drain_data0", 64'(data),  64'd1);
      for (int i = 1; i < DEPTH; i++) begin
         tick();
         check("drain_data",  64'(data),  64'(i + 1));
         check("drain_count", 64'(count), 64'(3 - i));
      end
      tick();
      check("drain_done", 64'(wr_req), 64'd0);

      // ready held low during a data phase
      drive(1'b1, 3'd2, 32'h200, 32'h12345678, 1'b1);
      tick();
      drive(1'b1, 3'd2, 32'h204, 32'h9, 1'b1);
      tick();
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      check("hold_data0",   64'(data),   64'h12345678);
      check("hold_d_addr0", 64'(d_addr), 64'h204);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("hold_data",   64'(data),   64'h12345678);
         check("hold_mask",   64'(mask),   64'hF);
         check("hold_d_addr", 64'(d_addr), 64'h204);
         check("hold_count",  64'(count),  64'd1);
      end
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      tick();
      check("release_data",  64'(data),  64'h9);
      check("release_count", 64'(count), 64'd0);
      tick();

      // reset with two queued and one in the data phase, plus a simultaneous request
      drive(1'b1, 3'd2, 32'h500, 32'hA, 1'b0);
      tick();
      drive(1'b1, 3'd2, 32'h504, 32'hB, 1'b1);
      tick();
      drive(1'b1, 3'd2, 32'h508, 32'hC, 1'b0);
      tick();
      check("pre_rst_count",  64'(count),  64'd2);
      check("pre_rst_wr_req", 64'(wr_req), 64'd1);
      check("pre_rst_data",   64'(data),   64'hA);
      rst = 1'b1;
      drive(1'b1, 3'd2, 32'h50C, 32'hD, 1'b1);
      tick();
      check("rst_count",  64'(count),  64'd0);
      check("rst_wr_req", 64'(wr_req), 64'd0);
      check("rst_htrans", 64'(htrans), 64'd0);
      check("rst_d_addr", 64'(d_addr), 64'd0);
      check("rst_data",   64'(data),   64'd0);
      rst = 1'b0;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      tick();

      // 64-bit instance
      drive64(1'b1, 3'd3, 32'h108, 64'h1122334455667788, 1'b1);
      tick();
      drive64(1'b0, 3'd0, 32'h0, 64'h0, 1'b1);
      check("sd_htrans", 64'(htrans_64), 64'd2);
      check("sd_d_addr", 64'(d_addr_64), 64'h108);
      tick();
      check("sd_mask",   64'(mask_64),   64'hFF);
      check("sd_data",   data_64,        64'h1122334455667788);
      check("sd_wr_req", 64'(wr_req_64), 64'd1);
      drive64(1'b1, 3'd3, 32'h10C, 64'h1, 1'b1);
      tick();
      drive64(1'b0, 3'd0, 32'h0, 64'h0, 1'b1);
      check("sd_mis_err",   64'(err_64),   64'd1);
      check("sd_mis_count", 64'(count_64), 64'd0);
      drive64(1'b1, 3'd0, 32'h105, 64'hAB, 1'b1);
      tick();
      drive64(1'b0, 3'd0, 32'h0, 64'h0, 1'b1);
      tick();
      check("sb64_data", data_64,        64'h0000AB0000000000);
      check("sb64_mask", 64'(mask_64),   64'h20);
      check("sb64_addr", 64'(d_addr_64), 64'h100);

      // randomized traffic on the 32-bit instance
      for (int c = 0; c < 3000; c++) begin
         int r;
         logic [2:0] f;
         rst = ($urandom_range(0, 199) == 0);
         r = int'($urandom_range(0, 9));
         f = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
         drive(1'($urandom_range(0, 1)), f, $urandom & 32'h0000_0FFF, $urandom,
               1'($urandom_range(0, 99) < (((c / 64) % 2) != 0 ? 85 : 20)));
         tick();
      end
      rst = 1'b0;
      drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      repeat (DEPTH + 2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
